// File: rtl/shadowmask_pkg.sv
// Shared constants and types for the shadow-mask command sequencer.
package shadowmask_pkg;
   localparam int LUT_DEPTH = 256;
   localparam int LUT_W     = 11;
   localparam int LUT_AW    = $clog2(LUT_DEPTH);
   localparam int LD_AW     = 9;
   localparam int CMD_W     = 16;

   localparam logic [2:0] OP_HDR  = 3'b000;
   localparam logic [2:0] OP_VMAX = 3'b001;
   localparam logic [2:0] OP_HMAX = 3'b010;
   localparam logic [2:0] OP_LUT  = 3'b011;

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_VMAX, S_HMAX, S_LUT} state_t;

   function automatic logic [CMD_W-1:0] cmd_word(input logic [2:0] op, input logic [12:0] arg);
      return {op, arg};
   endfunction
endpackage

// File: rtl/shadowmask_cmd_seq_if.sv
// Host download port and filter command port of the sequencer.
interface shadowmask_cmd_seq_if;
   import shadowmask_pkg::*;
   logic             ld_active;
   logic             ld_wr;
   logic [LD_AW-1:0] ld_addr;
   logic [CMD_W-1:0] ld_data;
   logic             cmd_wr;
   logic [CMD_W-1:0] cmd_in;
   logic             busy;

   modport master (output ld_active, ld_wr, ld_addr, ld_data, input cmd_wr, cmd_in, busy);
   modport slave  (input ld_active, ld_wr, ld_addr, ld_data, output cmd_wr, cmd_in, busy);
endinterface

// File: rtl/shadowmask_lut_ram.sv
// 256x11 simple dual-port LUT store: one write port, one registered read port.
module shadowmask_lut_ram
   import shadowmask_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [LUT_AW-1:0] waddr,
   input  logic [LUT_W-1:0]  wdata,
   input  logic [LUT_AW-1:0] raddr,
   output logic [LUT_W-1:0]  rdata
);
   logic [LUT_W-1:0] mem [LUT_DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/shadowmask_cmd_seq.sv
// Buffers a downloaded mask file and replays the full command stream to the
// shadow-mask filter starting at each vblank rising edge where a resend is due.
module shadowmask_cmd_seq
   import shadowmask_pkg::*;
(
   input  logic                  clk_sys,
   input  logic                  reset,
   shadowmask_cmd_seq_if.slave   bus,
   input  logic                  mask_enable,
   input  logic                  mask_rotate,
   input  logic                  mask_2x,
   input  logic                  vblank
);
   state_t            state, state_nx;
   logic              vblank_d, ld_active_d;
   logic              valid, pending, hdr_seen;
   logic [2:0]        sent, live;
   logic [3:0]        vmax, hmax;
   logic [LUT_AW-1:0] n_m1, lut_idx, lut_idx_nx;
   logic [LUT_AW-1:0] rd_addr, ram_waddr;
   logic [LUT_W-1:0]  rd_data;
   logic              cmd_wr_nx, busy_nx, start;
   logic [CMD_W-1:0]  cmd_in_nx;
   logic              vb_rise, ld_rise, ld_fall, ram_we, hdr_we;

   assign live    = {mask_enable, mask_rotate, mask_2x};
   assign vb_rise = vblank & ~vblank_d;
   assign ld_rise = bus.ld_active & ~ld_active_d;
   assign ld_fall = ~bus.ld_active & ld_active_d;
   assign hdr_we  = bus.ld_active & bus.ld_wr & (bus.ld_addr == '0);
   assign ram_we  = bus.ld_active & bus.ld_wr & (bus.ld_addr != '0) & (bus.ld_addr <= 9'd256);
   assign ram_waddr = LUT_AW'(bus.ld_addr - 9'd1);

   shadowmask_lut_ram u_ram (
      .clk   (clk_sys),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (bus.ld_data[LUT_W-1:0]),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   // Outputs are registered from the next state, so each word appears in the
   // cycle its state is entered. The RAM is read one edge ahead of use:
   // rd_data always holds the entry to emit at the coming edge.
   always_comb begin
      state_nx   = state;
      lut_idx_nx = lut_idx;
      rd_addr    = '0;
      cmd_wr_nx  = 1'b0;
      cmd_in_nx  = '0;
      start      = 1'b0;
      unique case (state)
         S_IDLE: begin
            // a settings change arriving with the edge counts as a request
            if ((pending || live != sent) && vb_rise && !bus.ld_active) begin
               start     = 1'b1;
               state_nx  = S_HDR;
               cmd_wr_nx = 1'b1;
               cmd_in_nx = cmd_word(OP_HDR, {9'b0, live[2] & valid, live[1], live[0], 1'b0});
            end
         end
         S_HDR: begin
            if (valid) begin
               state_nx  = S_VMAX;
               cmd_wr_nx = 1'b1;
               cmd_in_nx = cmd_word(OP_VMAX, {9'b0, vmax});
            end else begin
               state_nx  = S_IDLE;
            end
         end
         S_VMAX: begin
            state_nx  = S_HMAX;
            cmd_wr_nx = 1'b1;
            cmd_in_nx = cmd_word(OP_HMAX, {9'b0, hmax});
            rd_addr   = '0;
         end
         S_HMAX: begin
            state_nx   = S_LUT;
            lut_idx_nx = '0;
            cmd_wr_nx  = 1'b1;
            cmd_in_nx  = cmd_word(OP_LUT, {2'b0, rd_data});
            rd_addr    = LUT_AW'(1);
         end
         S_LUT: begin
            if (lut_idx == n_m1) begin
               state_nx   = S_IDLE;
            end else begin
               lut_idx_nx = lut_idx + 1'b1;
               cmd_wr_nx  = 1'b1;
               cmd_in_nx  = cmd_word(OP_LUT, {2'b0, rd_data});
               rd_addr    = lut_idx + LUT_AW'(2);
            end
         end
         default: state_nx = S_IDLE;
      endcase
      if (bus.ld_active) begin
         state_nx  = S_IDLE;
         cmd_wr_nx = 1'b0;
         cmd_in_nx = '0;
      end
      busy_nx = (state_nx != S_IDLE);
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state       <= S_IDLE;
         lut_idx     <= '0;
         vblank_d    <= 1'b0;
         ld_active_d <= 1'b0;
         valid       <= 1'b0;
         pending     <= 1'b1;
         hdr_seen    <= 1'b0;
         sent        <= '0;
         vmax        <= '0;
         hmax        <= '0;
         n_m1        <= '0;
         bus.cmd_wr  <= 1'b0;
         bus.cmd_in  <= '0;
         bus.busy    <= 1'b0;
      end else begin
         state       <= state_nx;
         lut_idx     <= lut_idx_nx;
         vblank_d    <= vblank;
         ld_active_d <= bus.ld_active;
         bus.cmd_wr  <= cmd_wr_nx;
         bus.cmd_in  <= cmd_in_nx;
         bus.busy    <= busy_nx;
         if (start) begin
            sent    <= live;
            pending <= 1'b0;
         end else if (live != sent) begin
            pending <= 1'b1;
         end
         // an aborted or completed load always forces a full resend
         if (ld_fall) begin
            pending <= 1'b1;
            if (hdr_seen) valid <= 1'b1;
         end
         if (ld_rise) hdr_seen <= 1'b0;
         if (hdr_we) begin
            hdr_seen <= 1'b1;
            vmax     <= bus.ld_data[3:0];
            hmax     <= bus.ld_data[7:4];
            n_m1     <= bus.ld_data[15:8];
         end
      end
   end
endmodule

// File: tb/tb_shadowmask_cmd_seq.sv
// Randomized bench for shadowmask_cmd_seq with a queue-based command stream model.
module tb_shadowmask_cmd_seq;
   import shadowmask_pkg::*;

   logic clk_sys = 1'b0;
   logic reset   = 1'b1;
   logic mask_enable = 1'b0, mask_rotate = 1'b0, mask_2x = 1'b0, vblank = 1'b0;

   shadowmask_cmd_seq_if sif();

   shadowmask_cmd_seq dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .bus         (sif.slave),
      .mask_enable (mask_enable),
      .mask_rotate (mask_rotate),
      .mask_2x     (mask_2x),
      .vblank      (vblank)
   );

   always #5 clk_sys = ~clk_sys;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   // reference model: file contents, flags and the queue of words still owed
   logic [10:0] m_ram [256];
   logic [3:0]  m_vmax, m_hmax;
   logic [7:0]  m_nm1;
   logic [2:0]  m_sent;
   bit          m_valid, m_pending, m_hdr_seen, m_prev_ld, m_prev_vb;
   int          m_q[$];          // -1 = the cycle spent returning to idle

   logic [15:0] ent [256];
   logic [15:0] got[$];
   int          got_cyc[$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d act=%h exp=%h", tag, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] gw(input int i);
      return (i < got.size()) ? 32'(got[i]) : 32'hDEAD_BEEF;
   endfunction

   task automatic model_step(output bit e_wr, output logic [15:0] e_word);
      logic [2:0] live;
      bit st;
      int w, h, a;
      live   = {mask_enable, mask_rotate, mask_2x};
      st     = 1'b0;
      e_wr   = 1'b0;
      e_word = '0;
      if (sif.ld_active) begin
         m_q.delete();
      end else if (m_q.size() > 0) begin
         w = m_q.pop_front();
         if (w >= 0) begin e_wr = 1'b1; e_word = 16'(w); end
      end else if ((m_pending || live != m_sent) && vblank && !m_prev_vb) begin
         st = 1'b1;
         h = 0;
         if (live[2] && m_valid) h += 8;
         if (live[1]) h += 4;
         if (live[0]) h += 2;
         e_wr = 1'b1;
         e_word = 16'(h);
         if (m_valid) begin
            m_q.push_back(32'h2000 + int'(m_vmax));
            m_q.push_back(32'h4000 + int'(m_hmax));
            for (int i = 0; i <= int'(m_nm1); i++) m_q.push_back(32'h6000 + int'(m_ram[i]));
         end
         m_q.push_back(-1);
      end
      if (st) begin m_sent = live; m_pending = 1'b0; end
      else if (live != m_sent) m_pending = 1'b1;
      if (!sif.ld_active && m_prev_ld) begin
         m_pending = 1'b1;
         if (m_hdr_seen) m_valid = 1'b1;
      end
      if (sif.ld_active && !m_prev_ld) m_hdr_seen = 1'b0;
      if (sif.ld_active && sif.ld_wr) begin
         a = int'(sif.ld_addr);
         if (a == 0) begin
            m_vmax = sif.ld_data[3:0];
            m_hmax = sif.ld_data[7:4];
            m_nm1  = sif.ld_data[15:8];
            m_hdr_seen = 1'b1;
         end else if (a <= 256) begin
            m_ram[a-1] = sif.ld_data[10:0];
         end
      end
      m_prev_ld = sif.ld_active;
      m_prev_vb = vblank;
   endtask

   task automatic tick();
      bit e_wr;
      logic [15:0] e_w;
      model_step(e_wr, e_w);
      @(posedge clk_sys);
      #1;
      cyc++;
      chk("cmd_wr", 32'(sif.cmd_wr), 32'(e_wr));
      chk("busy", 32'(sif.busy), 32'(e_wr));
      if (e_wr) chk("cmd_in", 32'(sif.cmd_in), 32'(e_w));
      if (sif.cmd_wr) begin got.push_back(sif.cmd_in); got_cyc.push_back(cyc); end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_vb();
      vblank = 1'b1; tick();
      vblank = 1'b0; tick();
   endtask

   task automatic do_load(input logic [15:0] hdr, input int n, input bit bad);
      sif.ld_active = 1'b1; sif.ld_wr = 1'b0; tick();
      sif.ld_wr = 1'b1;
      sif.ld_addr = 9'd0; sif.ld_data = hdr; tick();
      for (int i = 0; i < n; i++) begin
         sif.ld_addr = 9'(i + 1); sif.ld_data = ent[i]; tick();
      end
      if (bad) begin
         sif.ld_addr = 9'd300; sif.ld_data = ~ent[43]; tick();
      end
      sif.ld_wr = 1'b0; tick();
      sif.ld_active = 1'b0; tick();
   endtask

   initial begin
      sif.ld_active = 1'b0; sif.ld_wr = 1'b0; sif.ld_addr = '0; sif.ld_data = '0;
      m_valid = 1'b0; m_pending = 1'b1; m_sent = '0; m_hdr_seen = 1'b0;
      m_prev_ld = 1'b0; m_prev_vb = 1'b0;
      m_vmax = '0; m_hmax = '0; m_nm1 = '0;
      for (int i = 0; i < 256; i++) m_ram[i] = '0;

      repeat (3) @(posedge clk_sys);
      #1;
      chk("rst_cmd_wr", 32'(sif.cmd_wr), 32'd0);
      chk("rst_cmd_in", 32'(sif.cmd_in), 32'd0);
      chk("rst_busy", 32'(sif.busy), 32'd0);
      reset = 1'b0;

      // no file loaded: single disable header
      run(3); pulse_vb(); run(4);
      chk("noload_cnt", 32'(got.size()), 32'd1);
      chk("noload_word", gw(0), 32'h0000);

      // full load
      ent[0] = 16'h0700; ent[1] = 16'h0488; ent[2] = 16'h02FF; ent[3] = 16'h000F;
      do_load(16'h0321, 4, 1'b0);
      mask_enable = 1'b1; run(2);
      got.delete(); got_cyc.delete();
      pulse_vb(); run(10);
      chk("full_cnt", 32'(got.size()), 32'd7);
      chk("full_w0", gw(0), 32'h0008);
      chk("full_w1", gw(1), 32'h2001);
      chk("full_w2", gw(2), 32'h4002);
      chk("full_w3", gw(3), 32'h6700);
      chk("full_w4", gw(4), 32'h6488);
      chk("full_w5", gw(5), 32'h62FF);
      chk("full_w6", gw(6), 32'h600F);
      if (got_cyc.size() == 7) chk("full_span", 32'(got_cyc[6] - got_cyc[0]), 32'd6);

      // setting change mid-frame waits for the vblank edge
      got.delete(); got_cyc.delete();
      mask_rotate = 1'b1; run(20);
      chk("chg_quiet", 32'(got.size()), 32'd0);
      pulse_vb(); run(10);
      chk("chg_cnt", 32'(got.size()), 32'd7);
      chk("chg_hdr", gw(0), 32'h000C);

      // abort during LUT entry 2, then reload and resend
      got.delete(); got_cyc.delete();
      mask_2x = 1'b1; run(2);
      vblank = 1'b1; tick();
      vblank = 1'b0; run(5);
      sif.ld_active = 1'b1; tick();
      chk("abort_cnt", 32'(got.size()), 32'd6);
      chk("abort_last", gw(5), 32'h62FF);
      do_load(16'h0321, 4, 1'b0);
      got.delete(); got_cyc.delete();
      pulse_vb(); run(10);
      chk("resend_cnt", 32'(got.size()), 32'd7);
      chk("resend_hdr", gw(0), 32'h000E);
      chk("resend_last", gw(6), 32'h600F);

      // N=256 plus an out-of-range write at address 300
      for (int i = 0; i < 256; i++) ent[i] = 16'($urandom);
      do_load({8'hFF, 8'($urandom)}, 256, 1'b1);
      mask_2x = 1'b0;
      got.delete(); got_cyc.delete();
      pulse_vb(); run(265);
      chk("n256_cnt", 32'(got.size()), 32'd259);
      if (got_cyc.size() == 259) chk("n256_last", 32'(got_cyc[258] - got_cyc[0]), 32'd258);
      chk("n256_hdr", gw(0), 32'h000C);

      // vblank edge during replay without a pending change
      mask_rotate = 1'b0; run(1);
      got.delete(); got_cyc.delete();
      pulse_vb(); run(20); pulse_vb(); run(260);
      chk("vbrep_cnt", 32'(got.size()), 32'd259);

      // settings change on the same cycle as the vblank edge
      got.delete(); got_cyc.delete();
      vblank = 1'b1; mask_2x = 1'b1; mask_enable = 1'b0; tick();
      vblank = 1'b0; run(262);
      chk("same_cnt", 32'(got.size()), 32'd259);
      chk("same_hdr", gw(0), 32'h0002);

      // random soak: settings, vblank and short loads
      for (int i = 0; i < 600; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 3) mask_enable = ~mask_enable;
         else if (r < 6) mask_rotate = ~mask_rotate;
         else if (r < 9) mask_2x = ~mask_2x;
         if ($urandom_range(0, 11) == 0) vblank = ~vblank;
         if (i % 200 == 60) begin
            for (int k = 0; k < 8; k++) ent[k] = 16'($urandom);
            do_load({8'($urandom_range(0, 7)), 8'($urandom)}, 8, 1'b0);
         end
         tick();
      end
      vblank = 1'b0; run(270);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
